// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch controller
package fetch_pkg;

    localparam int INST_W = 32;
    localparam logic [INST_W-1:0] HALT_WORD = 32'hFC00_0000;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        END
    } fetch_state_t;

    typedef struct packed {
        logic [31:0]       pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    // 33-bit bound check so a wrapped pc+4 can never look in range
    function automatic logic word_fits(input logic [31:0] pc, input logic [32:0] limit);
        return ({1'b0, pc} + 33'd4) <= limit;
    endfunction

endpackage

// File: rtl/inst_fetch_ctrl_if.sv
// rtl/inst_fetch_ctrl_if.sv - ROM, redirect and issue-queue signals of the fetch controller
interface inst_fetch_ctrl_if;
    import fetch_pkg::*;

    logic              rom_nrd;
    logic [31:0]       rom_addr;
    logic [INST_W-1:0] rom_data;
    logic              redirect;
    logic [31:0]       redirect_pc;
    logic              deq_ready;
    logic              deq_valid;
    logic [INST_W-1:0] deq_inst;
    logic [31:0]       deq_pc;
    logic              done;

    modport master (
        output rom_nrd, rom_addr, deq_valid, deq_inst, deq_pc, done,
        input  rom_data, redirect, redirect_pc, deq_ready
    );

    modport slave (
        input  rom_nrd, rom_addr, deq_valid, deq_inst, deq_pc, done,
        output rom_data, redirect, redirect_pc, deq_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - instruction queue holding fetched {pc, inst} entries
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  fetch_entry_t  wdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count,
    output fetch_entry_t  head
);

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    // Pointers wrap naturally (DEPTH is a power of two); occupancy kept separately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Entry storage; contents are only meaningful while counted, so no reset
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/inst_fetch_ctrl.sv
// rtl/inst_fetch_ctrl.sv - program counter, fetch FSM and ROM strobe for the Tomasulo core
module inst_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned ROM_BYTES = 100,
    parameter logic [31:0] RESET_PC  = 32'h0
) (
    input  logic               clk,
    input  logic               rst,
    inst_fetch_ctrl_if.master  bus
);

    localparam logic [32:0] ROM_LIMIT = 33'(ROM_BYTES);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    fetch_state_t  state;
    logic [31:0]   pc;
    logic [31:0]   redir_pc;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    fetch_entry_t  head;
    fetch_entry_t  wdata;
    logic          pop;
    logic          can_enq;
    logic          in_range;
    logic          fetch;
    logic          push;

    assign redir_pc = bus.redirect_pc & ~32'd3;
    assign pop      = !empty && bus.deq_ready;
    // A pop in the same cycle frees a slot, so a full queue does not stall fetch
    assign can_enq  = !full || pop;
    assign in_range = word_fits(pc, ROM_LIMIT);
    assign fetch    = (state == RUN) && can_enq && in_range;
    assign push     = fetch && !bus.redirect;
    assign wdata    = '{pc: pc, inst: bus.rom_data};

    assign bus.rom_nrd   = !fetch;
    assign bus.rom_addr  = pc;
    assign bus.deq_valid = !empty;
    assign bus.deq_inst  = empty ? '0 : head.inst;
    assign bus.deq_pc    = empty ? '0 : head.pc;
    assign bus.done      = (state == END) && (count == '0);

    // Fetch FSM and PC; redirect overrides everything, including the halt check
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= BOOT;
            pc    <= RESET_PC;
        end else if (bus.redirect) begin
            pc    <= redir_pc;
            state <= word_fits(redir_pc, ROM_LIMIT) ? RUN : END;
        end else begin
            case (state)
                BOOT: state <= RUN;
                RUN: begin
                    if (!in_range) begin
                        state <= END;
                    end else if (fetch) begin
                        pc <= pc + 32'd4;
                        if (bus.rom_data == HALT_WORD) begin
                            state <= END;
                        end
                    end
                end
                END:     state <= END;
                default: state <= BOOT;
            endcase
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (bus.redirect),
        .wdata (wdata),
        .full  (full),
        .empty (empty),
        .count (count),
        .head  (head)
    );

endmodule

// File: doc/inst_fetch_ctrl.md
# inst_fetch_ctrl

Instruction fetch controller for the Tomasulo core. It owns the program counter and drives the byte-addressed, big-endian, combinational instruction ROM through its active-low read strobe and address. Fetched words are buffered with their PCs in a small queue for the issue stage. It stops fetching on a full queue, the halt word, or the end of ROM, and restarts from a new PC on a redirect.

## Interface
- DEPTH, 4, instruction-queue entries (power of two, ≥2)
- ROM_BYTES, 100, ROM size in bytes; a word at pc is fetchable iff pc+4 ≤ ROM_BYTES
- RESET_PC, 32'h0, PC loaded on reset (word aligned)
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- rom_nrd  out  1  ROM read strobe, active low
- rom_addr  out  32  ROM byte address (always = pc)
- rom_data  in  32  ROM word, valid combinationally in the same cycle rom_nrd=0
- redirect  in  1  flush queue and restart fetch at redirect_pc
- redirect_pc  in  32  new PC; bits[1:0] forced to 0
- deq_ready  in  1  issue stage accepts head entry
- deq_valid  out  1  queue non-empty
- deq_inst  out  32  head instruction (0 when deq_valid=0)
- deq_pc  out  32  head PC (0 when deq_valid=0)
- done  out  1  state END and queue empty

## Operation
- States: BOOT, RUN, END.
- BOOT: entered on reset. rom_nrd=1. Goes unconditionally to RUN on the next edge, unless a redirect is present.
- RUN conditions:
  - can_enq = (count<DEPTH) or (deq_valid and deq_ready).
  - rom_nrd=0 iff can_enq and pc+4 ≤ ROM_BYTES.
- RUN actions:
  - On an edge with rom_nrd=0, push {pc, rom_data}, then pc ← pc+4.
  - If the pushed word equals HALT_WORD (32'hFC00_0000), go to END; the halt word itself is enqueued.
  - If pc+4 > ROM_BYTES, rom_nrd=1 and go to END with no push.
- END: rom_nrd=1. The queue keeps draining to the issue stage.
- Dequeue: a pop occurs on an edge with deq_valid and deq_ready. A push and a pop in the same cycle leave count unchanged; this is legal at count=DEPTH.
- Redirect: highest priority, in any state.
  - At the edge, the queue is emptied (count←0), the same-cycle push is discarded, and pc←{redirect_pc[31:2],2'b00}.
  - Next state is RUN if the new pc+4 ≤ ROM_BYTES, else END.
  - A deq handshake in the redirect cycle is still a valid transfer to the consumer.
- PC arithmetic is 32-bit unsigned and wraps silently. The ROM_BYTES bound check is done in 33 bits so that wrap never appears in range.
- Reset values: pc=RESET_PC, state=BOOT, count=0, rom_nrd=1, rom_addr=RESET_PC, deq_valid=0, deq_inst=0, deq_pc=0, done=0.
- Reset mid-operation clears everything asynchronously; no partial push survives.

## Timing
- Fetch latency: the ROM is sampled at the edge ending the cycle with rom_nrd=0. That entry is visible on deq_* in the following cycle, so fetch to deq_valid is 1 cycle.
- After reset release:
  - edge 1: BOOT→RUN.
  - cycle 1: rom_nrd=0, rom_addr=RESET_PC.
  - edge 2: push.
  - cycle 2: deq_valid=1, deq_pc=RESET_PC.
- Throughput: one word per cycle while the consumer holds deq_ready=1. There is no bubble at full.
- Redirect: first fetch at redirect_pc is in the cycle after the redirect edge. deq_valid=0 in that cycle.
- done rises in the cycle after the last pop in END.

## Structure
- Package fetch_pkg holds:
  - state enum {BOOT, RUN, END};
  - HALT_WORD;
  - INST_W=32;
  - entry struct {pc[31:0], inst[31:0]}.
- Sub-module fetch_fifo: synchronous FIFO of DEPTH entries.
  - Ports: push, pop, flush, full, empty, count, head.
  - Pointers wrap modulo DEPTH; the count is kept as a separate counter.
- The top level holds only the PC, the FSM and the ROM strobe logic.

## Test plan
- Reset, deq_ready=1, ROM words 0x11111111, 0x22222222, 0x33333333 at 0/4/8 → deq_pc 0,4,8 on consecutive cycles starting cycle 2; rom_nrd low from cycle 1.
- deq_ready=0 for 10 cycles → exactly DEPTH=4 pushes (pc 0..12), then rom_nrd=1 and rom_addr=16. Raising deq_ready and holding it resumes one push per cycle with no lost or duplicated PC.
- Halt word at address 8 → entries 0,4,8 enqueued, rom_nrd=1 from the next cycle, done=1 one cycle after entry 8 pops.
- ROM_BYTES=12, no halt → pushes at 0,4,8, END with pc=12, done after drain.
- Redirect to 0x2B with 3 entries queued and a simultaneous pop → queue empty next cycle, rom_addr=0x28, next deq_pc=0x28.
- Assert rst while count=3 mid-stream → all outputs return to reset values immediately (asynchronously); the BOOT sequence restarts at RESET_PC.
